muldiv_unit: RTL

- Parametrised multi-cycle RV32M execution unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Sits beside the single-cycle integer ALU in the execute stage. Decode routes funct3-selected M-extension ops here.
- Uses a valid/ready request and response handshake. Pipeline control uses the handshake to stall, and uses kill to abandon work on a branch flush.

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_divider.sv | 90 +++++++++
 rtl/muldiv_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the RV32M multiply/divide unit: funct3 op encoding, FSM states
// and the op-class helper used by decode and the unit itself.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } md_state_t;

  function automatic logic is_div(input muldiv_op_t op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Iterative restoring divider on unsigned magnitudes; retires DIV_RADIX_LOG2
// quotient bits per cycle and pulses done once the last iteration has landed.
module muldiv_divider #(
  parameter int XLEN           = 32,
  parameter int DIV_RADIX_LOG2 = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  localparam int ITER = XLEN / DIV_RADIX_LOG2;
  localparam int CW   = $clog2(ITER);

  logic            busy_q, busy_d, done_q, done_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [XLEN-1:0] quo_t, rem_t;
  logic [XLEN:0]   trial;

  // The partial remainder stays below the divisor, so one extra bit covers the shift-in.
  always_comb begin
    quo_t = quo_q;
    rem_t = rem_q;
    trial = '0;
    for (int i = 0; i < DIV_RADIX_LOG2; i++) begin
      trial = {rem_t, quo_t[XLEN-1]};
      quo_t = {quo_t[XLEN-2:0], 1'b0};
      if (trial >= {1'b0, dvs_q}) begin
        trial    = trial - {1'b0, dvs_q};
        quo_t[0] = 1'b1;
      end
      rem_t = trial[XLEN-1:0];
    end
  end

  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    if (abort) begin
      busy_d = 1'b0;
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      quo_d  = dividend;
      rem_d  = '0;
      dvs_d  = divisor;
    end else if (busy_q) begin
      quo_d = quo_t;
      rem_d = rem_t;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(ITER - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
    end
  end

  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M execute unit: pipelined multiplier inline, iterative divider
// as a sub-block, one op in flight with valid/ready on both sides and a flush kill.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int MUL_STAGES     = 2,
  parameter int DIV_RADIX_LOG2 = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_op1,
  input  logic [XLEN-1:0] req_op2,
  input  logic            kill,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_res,
  output logic            busy
);
  localparam int CW = $clog2(MUL_STAGES) + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t       state_q, state_d;
  muldiv_op_t      op_q, op_d, req_op_e;
  logic [XLEN-1:0] op1_q, op1_d, op2_q, op2_d, res_q, res_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            spec_q, spec_d;

  logic            accept, req_signed, req_spec, div_start, div_done;
  logic [XLEN-1:0] op1_mag, op2_mag, div_quo, div_rem;

  assign req_op_e   = muldiv_op_t'(req_op);
  assign accept     = req_valid && (state_q == ST_IDLE) && !kill;
  assign req_signed = req_op_e inside {DIV, REM};
  assign req_spec   = is_div(req_op_e) && ((req_op2 == '0) ||
                      (req_signed && (req_op1 == MOST_NEG) && (req_op2 == '1)));
  assign op1_mag    = (req_signed && req_op1[XLEN-1]) ? -req_op1 : req_op1;
  assign op2_mag    = (req_signed && req_op2[XLEN-1]) ? -req_op2 : req_op2;
  // Divide-by-zero and overflow never enter the divider; they resolve from latched operands.
  assign div_start  = accept && is_div(req_op_e) && !req_spec;

  muldiv_divider #(
    .XLEN           (XLEN),
    .DIV_RADIX_LOG2 (DIV_RADIX_LOG2)
  ) u_divider (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .abort     (kill),
    .dividend  (op1_mag),
    .divisor   (op2_mag),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  logic              mul_a_sx, mul_b_sx;
  logic [2*XLEN-1:0] mul_a, mul_b, mul_full;
  logic [2*XLEN-1:0] mul_tap [MUL_STAGES];

  assign mul_a_sx   = (op_q inside {MULH, MULHSU}) && op1_q[XLEN-1];
  assign mul_b_sx   = (op_q == MULH) && op2_q[XLEN-1];
  assign mul_a      = {{XLEN{mul_a_sx}}, op1_q};
  assign mul_b      = {{XLEN{mul_b_sx}}, op2_q};
  assign mul_tap[0] = mul_a * mul_b;

  // res_q is the last product register, so MUL_STAGES-1 stages sit in between.
  for (genvar gi = 1; gi < MUL_STAGES; gi++) begin : g_mul_pipe
    logic [2*XLEN-1:0] stage_q;
    always_ff @(posedge clk) stage_q <= mul_tap[gi-1];
    assign mul_tap[gi] = stage_q;
  end

  assign mul_full = mul_tap[MUL_STAGES-1];

  logic            div_signed, div_is_rem;
  logic [XLEN-1:0] mul_res, fix_res, spec_res;

  always_comb begin
    div_signed = op_q inside {DIV, REM};
    div_is_rem = op_q inside {REM, REMU};
    mul_res    = (op_q == MUL) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
    if (div_is_rem)
      fix_res = (div_signed && op1_q[XLEN-1]) ? -div_rem : div_rem;
    else
      fix_res = (div_signed && (op1_q[XLEN-1] ^ op2_q[XLEN-1])) ? -div_quo : div_quo;
    if (op2_q == '0)
      spec_res = div_is_rem ? op1_q : '1;
    else
      spec_res = div_is_rem ? '0 : op1_q;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    spec_d  = spec_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = req_op_e;
          op1_d   = req_op1;
          op2_d   = req_op2;
          cnt_d   = '0;
          spec_d  = req_spec;
          state_d = is_div(req_op_e) ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL: begin
        if (cnt_q == CW'(MUL_STAGES - 1)) begin
          res_d   = mul_res;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DIV: begin
        if (spec_q) begin
          res_d   = spec_res;
          state_d = ST_DONE;
        end else if (div_done) begin
          res_d   = fix_res;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (kill) begin
      state_d = ST_IDLE;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= MUL;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      spec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      spec_q  <= spec_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign resp_res   = res_q;

endmodule
